stream_source: RTL and testbench
================================

STREAM_SOURCE -- requirements
Module: stream_source

Interface
REQ-001 SHALL have parameter NB, default 12, giving the sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, giving the sample buffer depth in words (power of two); AW = log2(DEPTH).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port wr_en, input, 1 bit: write strobe that loads wr_data into the buffer.
REQ-006 SHALL have port wr_data, input, NB bits: sample to load.
REQ-007 SHALL have port clear, input, 1 bit: empties the buffer and clears overflow.
REQ-008 SHALL have port start, input, 1 bit: begins playback of the loaded samples.
REQ-009 SHALL have port gap, input, 8 bits: number of idle cycles between transmitted samples.
REQ-010 SHALL have port vOut, output, 1 bit: marks dOut valid for exactly that cycle (valid-only protocol, no backpressure).
REQ-011 SHALL have port dOut, output, NB bits: transmitted sample.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when playback completes.
REQ-013 SHALL have port busy, output, 1 bit: high while not in IDLE.
REQ-014 SHALL have port count, output, AW+1 bits: number of samples loaded.
REQ-015 SHALL have port overflow, output, 1 bit: sticky flag for a write attempted while full.

Function
REQ-016 SHALL implement the states IDLE, SEND, GAP and DONE; busy = (state != IDLE).
REQ-017 SHALL, in IDLE with wr_en=1 and count<DEPTH, write wr_data at index count and increment count on the next edge.
REQ-018 SHALL ignore wr_en when count=DEPTH and instead set overflow to 1; overflow stays 1 until clear or rst.
REQ-019 SHALL ignore wr_en whenever busy=1; this does not set overflow.
REQ-020 SHALL, when clear=1 in IDLE, set count and overflow to 0; clear SHALL be ignored while busy; clear SHALL take priority over a simultaneous wr_en.
REQ-021 SHALL, on start=1 in IDLE with count>0, capture gap into an internal register and reset the read index to 0; the next state is SEND.
REQ-022 SHALL, on start=1 in IDLE with count=0, go to DONE with no vOut asserted.
REQ-023 SHALL treat start asserted while busy as ignored; start SHALL take priority over wr_en and clear in the same cycle.
REQ-024 SHALL, in SEND, drive vOut=1 with dOut=buffer[read index]; outputs are registered, so the first vOut appears exactly 1 cycle after the start cycle.
REQ-025 SHALL, after SEND of the last sample (read index = count-1), go to DONE.
REQ-026 SHALL, after SEND of any other sample, increment the read index and go to SEND if the captured gap = 0, otherwise to GAP.
REQ-027 SHALL remain in GAP for exactly the captured gap cycles with vOut=0, then go to SEND; changes to gap during playback have no effect.
REQ-028 SHALL, in DONE, assert done=1 for one cycle and then return to IDLE.
REQ-029 SHALL hold dOut at the last transmitted value whenever vOut=0.
REQ-030 SHALL leave buffer contents and count unchanged by playback, so a second start replays the same samples.
REQ-031 SHALL, for N samples with gap G, produce exactly N vOut pulses spaced G+1 cycles apart, with done exactly 1 cycle after the last vOut.

Reset
REQ-032 SHALL, when rst=1, force state IDLE, vOut=0, dOut=0, done=0, busy=0, count=0, overflow=0 and read index 0 on the next edge; buffer contents need not be reset.
REQ-033 SHALL let rst mid-playback abort immediately, with no further vOut and no done pulse.

Verification
REQ-034 SHALL cover: load 0x001,0x7FF,0x800 then start with gap=0 -> vOut high on cycles t+1..t+3 with dOut 0x001,0x7FF,0x800, and done at t+4.
REQ-035 SHALL cover: the same load with gap=2 -> vOut at t+1, t+4, t+7; done at t+8; vOut=0 in between; dOut holds its value.
REQ-036 SHALL cover: start with count=0 -> no vOut and done at t+1; also DEPTH+1 writes -> count=DEPTH and overflow=1, then clear -> count=0 and overflow=0.
REQ-037 SHALL cover: wr_en, clear and start pulsed during playback -> ignored, with count and the output sequence unchanged.
REQ-038 SHALL cover: rst asserted after the 2nd vOut of 4 -> next edge all outputs at reset values, no further vOut, no done.
REQ-039 SHALL cover: a second start after done -> an identical vOut/dOut sequence.

Source files
------------

// File: rtl/stream_source_if.sv
// stream_source_if: load/control/playback signal bundle for stream_source.
interface stream_source_if #(
  parameter int NB    = 12,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);
  logic          wr_en;
  logic [NB-1:0] wr_data;
  logic          clear;
  logic          start;
  logic [7:0]    gap;
  logic          vOut;
  logic [NB-1:0] dOut;
  logic          done;
  logic          busy;
  logic [AW:0]   count;
  logic          overflow;
  modport master (
    output wr_en, wr_data, clear, start, gap,
    input  vOut, dOut, done, busy, count, overflow
  );
  modport slave (
    input  wr_en, wr_data, clear, start, gap,
    output vOut, dOut, done, busy, count, overflow
  );
endinterface

// File: rtl/stream_source.sv
// stream_source: sample buffer loaded in IDLE and replayed as valid-only pulses
// with a programmable idle gap between samples.
module stream_source #(
  parameter int NB    = 12,
  parameter int DEPTH = 16
) (
  input logic            clk,
  input logic            rst,
  stream_source_if.slave s
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [7:0]    gap_q, gap_d, gcnt_q, gcnt_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d, v_q, v_d, done_q, done_d;
  logic [NB-1:0] dout_q, dout_d;
  logic [NB-1:0] mem [DEPTH];
  logic          idle, last, wr;
  assign idle = state_q == IDLE;
  assign last = {1'b0, rd_q} == count_q - 1'b1;
  assign wr   = idle && s.wr_en && !s.start && !s.clear && count_q != FULL;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      v_q     <= v_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
    end
  end
  always_ff @(posedge clk) if (wr) mem[count_q[AW-1:0]] <= s.wr_data;
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (s.start) begin
          state_d = count_q == '0 ? DONE : SEND;
          rd_d    = '0;
          gap_d   = s.gap;
        end else if (s.clear) begin
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (s.wr_en) begin
          if (count_q == FULL) ovf_d = 1'b1;
          else count_d = count_q + 1'b1;
        end
      end
      SEND: begin
        if (last) state_d = DONE;
        else begin
          rd_d    = rd_q + 1'b1;
          gcnt_d  = gap_q;
          state_d = gap_q == 8'd0 ? SEND : GAP;
        end
      end
      GAP: begin
        gcnt_d  = gcnt_q - 8'd1;
        state_d = gcnt_q == 8'd1 ? SEND : GAP;
      end
      DONE: state_d = IDLE;
    endcase
  end
  // outputs are registered from the next state so vOut/done align with SEND/DONE
  always_comb begin
    v_d    = state_d == SEND;
    done_d = state_d == DONE;
    dout_d = v_d ? mem[rd_d] : dout_q;
  end
  assign s.vOut     = v_q;
  assign s.dOut     = dout_q;
  assign s.done     = done_q;
  assign s.busy     = !idle;
  assign s.count    = count_q;
  assign s.overflow = ovf_q;
endmodule

// File: tb/tb_stream_source.sv
// tb_stream_source: directed checks of load, playback timing, overflow, clear and reset abort.
module tb_stream_source;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [11:0] exp_d [4];
  stream_source_if #(.NB(12), .DEPTH(16)) sif ();
  stream_source #(.NB(12), .DEPTH(16)) dut (.clk(clk), .rst(rst), .s(sif.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [11:0] d);
    sif.wr_en = 1'b1;
    sif.wr_data = d;
    tick();
    sif.wr_en = 1'b0;
  endtask
  task automatic play(input int n, input int g, input bit disturb);
    int last_v;
    int idx;
    logic v;
    last_v = 1 + (n - 1) * (g + 1);
    sif.gap = 8'(g);
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    for (int c = 1; c <= last_v + 1; c++) begin
      v = ((c - 1) % (g + 1) == 0) && c <= last_v;
      idx = (c - 1) / (g + 1);
      if (idx > n - 1) idx = n - 1;
      chk($sformatf("vOut_c%0d", c), 32'(sif.vOut), 32'(v));
      chk($sformatf("dOut_c%0d", c), 32'(sif.dOut), 32'(exp_d[idx]));
      chk($sformatf("done_c%0d", c), 32'(sif.done), 32'(c == last_v + 1));
      chk($sformatf("busy_c%0d", c), 32'(sif.busy), 32'd1);
      if (disturb && c == 2) begin
        sif.wr_en = 1'b1;
        sif.wr_data = 12'h123;
        sif.clear = 1'b1;
        sif.start = 1'b1;
        sif.gap = 8'd5;
      end else begin
        sif.wr_en = 1'b0;
        sif.clear = 1'b0;
        sif.start = 1'b0;
      end
      tick();
    end
    chk("busy_after", 32'(sif.busy), 32'd0);
    chk("done_after", 32'(sif.done), 32'd0);
  endtask
  initial begin
    rst = 1'b1;
    sif.wr_en = 1'b0;
    sif.wr_data = '0;
    sif.clear = 1'b0;
    sif.start = 1'b0;
    sif.gap = '0;
    tick();
    tick();
    chk("rst_vOut", 32'(sif.vOut), 32'd0);
    chk("rst_dOut", 32'(sif.dOut), 32'd0);
    chk("rst_done", 32'(sif.done), 32'd0);
    chk("rst_busy", 32'(sif.busy), 32'd0);
    chk("rst_count", 32'(sif.count), 32'd0);
    chk("rst_ovf", 32'(sif.overflow), 32'd0);
    rst = 1'b0;
    wr(12'h001);
    wr(12'h7FF);
    wr(12'h800);
    chk("load_count", 32'(sif.count), 32'd3);
    exp_d[0] = 12'h001;
    exp_d[1] = 12'h7FF;
    exp_d[2] = 12'h800;
    exp_d[3] = 12'h800;
    play(3, 0, 1'b0);
    play(3, 2, 1'b0);
    play(3, 0, 1'b1);
    chk("disturb_count", 32'(sif.count), 32'd3);
    chk("disturb_ovf", 32'(sif.overflow), 32'd0);
    play(3, 0, 1'b0);
    sif.clear = 1'b1;
    sif.wr_en = 1'b1;
    tick();
    sif.clear = 1'b0;
    sif.wr_en = 1'b0;
    chk("clear_count", 32'(sif.count), 32'd0);
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    chk("empty_vOut", 32'(sif.vOut), 32'd0);
    chk("empty_done", 32'(sif.done), 32'd1);
    chk("empty_busy", 32'(sif.busy), 32'd1);
    tick();
    chk("empty_done2", 32'(sif.done), 32'd0);
    chk("empty_busy2", 32'(sif.busy), 32'd0);
    chk("empty_vOut2", 32'(sif.vOut), 32'd0);
    for (int i = 0; i < 16; i++) wr(12'(i));
    chk("full_count", 32'(sif.count), 32'd16);
    chk("full_ovf0", 32'(sif.overflow), 32'd0);
    wr(12'hFFF);
    chk("ovf_count", 32'(sif.count), 32'd16);
    chk("ovf_flag", 32'(sif.overflow), 32'd1);
    tick();
    chk("ovf_sticky", 32'(sif.overflow), 32'd1);
    sif.clear = 1'b1;
    tick();
    sif.clear = 1'b0;
    chk("clr_count", 32'(sif.count), 32'd0);
    chk("clr_ovf", 32'(sif.overflow), 32'd0);
    wr(12'h00A);
    wr(12'h00B);
    wr(12'h00C);
    wr(12'h00D);
    chk("load4_count", 32'(sif.count), 32'd4);
    sif.gap = 8'd1;
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    chk("ab_v1", 32'(sif.vOut), 32'd1);
    chk("ab_d1", 32'(sif.dOut), 32'h00A);
    tick();
    chk("ab_gap", 32'(sif.vOut), 32'd0);
    tick();
    chk("ab_v2", 32'(sif.vOut), 32'd1);
    chk("ab_d2", 32'(sif.dOut), 32'h00B);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ab_vOut", 32'(sif.vOut), 32'd0);
    chk("ab_dOut", 32'(sif.dOut), 32'd0);
    chk("ab_done", 32'(sif.done), 32'd0);
    chk("ab_busy", 32'(sif.busy), 32'd0);
    chk("ab_count", 32'(sif.count), 32'd0);
    chk("ab_ovf", 32'(sif.overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("ab_quiet_v%0d", i), 32'(sif.vOut), 32'd0);
      chk($sformatf("ab_quiet_d%0d", i), 32'(sif.done), 32'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
